// File: rtl/memory_access_stage.sv
// memory_access_stage: pipeline MEM stage issuing req/ack data memory accesses with
// load formatting, upstream stall and access timeout.
module memory_access_stage #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic        load_in,
  input  logic        store_in,
  input  logic        byte_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] store_data_in,
  input  logic [3:0]  rd_in,
  input  logic        link_in,
  input  logic        writeback_enable_in,
  input  logic [3:0]  cpsr_status_in,
  output logic        stall_out,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        valid_out,
  output logic [31:0] data_out,
  output logic [3:0]  rd_out,
  output logic        link_out,
  output logic        writeback_enable_out,
  output logic [3:0]  cpsr_status_out,
  output logic        mem_fault_out
);
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t      state;
  logic [7:0]  cnt;
  logic        op_load, op_byte, op_link, op_wb;
  logic [1:0]  op_lo;
  logic [31:0] op_alu, rot, load_data;
  logic [3:0]  op_rd, op_cpsr;
  logic        is_mem, timeout;
  always_comb begin
    is_mem    = valid_in && (load_in || store_in);
    timeout   = cnt == 8'(TIMEOUT_CYCLES - 1);
    stall_out = state == IDLE ? is_mem : !mem_ack && !timeout;
    rot       = 32'({mem_rdata, mem_rdata} >> {op_lo, 3'b000});
    load_data = op_byte ? {24'b0, rot[7:0]} : rot;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      valid_out <= 1'b0;
      data_out <= '0;
      rd_out <= '0;
      link_out <= 1'b0;
      writeback_enable_out <= 1'b0;
      cpsr_status_out <= '0;
      mem_fault_out <= 1'b0;
      op_load <= 1'b0;
      op_byte <= 1'b0;
      op_lo <= '0;
      op_alu <= '0;
      op_rd <= '0;
      op_link <= 1'b0;
      op_wb <= 1'b0;
      op_cpsr <= '0;
    end else begin
      mem_fault_out <= 1'b0;
      if (state == IDLE) begin
        if (!valid_in) begin
          valid_out <= 1'b0;
          writeback_enable_out <= 1'b0;
        end else if (!is_mem) begin
          valid_out <= 1'b1;
          data_out <= alu_result_in;
          rd_out <= rd_in;
          link_out <= link_in;
          writeback_enable_out <= writeback_enable_in;
          cpsr_status_out <= cpsr_status_in;
        end else begin
          state <= ACCESS;
          cnt <= '0;
          valid_out <= 1'b0;
          writeback_enable_out <= 1'b0;
          op_load <= load_in;
          op_byte <= byte_in;
          op_lo <= addr_in[1:0];
          op_alu <= alu_result_in;
          op_rd <= rd_in;
          op_link <= link_in;
          op_wb <= writeback_enable_in;
          op_cpsr <= cpsr_status_in;
          mem_req <= 1'b1;
          mem_we <= !load_in;
          mem_addr <= {addr_in[31:2], 2'b00};
          mem_wdata <= byte_in ? {4{store_data_in[7:0]}} : store_data_in;
          mem_wstrb <= load_in ? 4'b0000 : byte_in ? 4'b0001 << addr_in[1:0] : 4'b1111;
        end
      end else if (mem_ack || timeout) begin
        state <= IDLE;
        mem_req <= 1'b0;
        valid_out <= 1'b1;
        rd_out <= op_rd;
        link_out <= op_link;
        cpsr_status_out <= op_cpsr;
        writeback_enable_out <= mem_ack && op_load && op_wb;
        mem_fault_out <= !mem_ack;
        if (mem_ack) data_out <= op_load ? load_data : op_alu;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_memory_access_stage.sv
// tb_memory_access_stage: directed and randomized checks of the MEM stage against a
// transaction-level model of the memory access rules.
module tb_memory_access_stage;
  localparam int T = 15;
  logic        clk = 0, reset = 1;
  logic        valid_in = 0, load_in = 0, store_in = 0, byte_in = 0;
  logic [31:0] addr_in = 0, alu_result_in = 0, store_data_in = 0;
  logic [3:0]  rd_in = 0, cpsr_status_in = 0;
  logic        link_in = 0, writeback_enable_in = 0;
  logic        stall_out, mem_req, mem_we, mem_ack = 0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = 0, data_out;
  logic [3:0]  mem_wstrb, rd_out, cpsr_status_out;
  logic        valid_out, link_out, writeback_enable_out, mem_fault_out;
  int vectors = 0, errors = 0;

  memory_access_stage #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .load_in(load_in), .store_in(store_in),
    .byte_in(byte_in), .addr_in(addr_in), .alu_result_in(alu_result_in),
    .store_data_in(store_data_in), .rd_in(rd_in), .link_in(link_in),
    .writeback_enable_in(writeback_enable_in), .cpsr_status_in(cpsr_status_in),
    .stall_out(stall_out), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .valid_out(valid_out), .data_out(data_out), .rd_out(rd_out), .link_out(link_out),
    .writeback_enable_out(writeback_enable_out), .cpsr_status_out(cpsr_status_out),
    .mem_fault_out(mem_fault_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] load_model(input logic by, input logic [1:0] lo, input logic [31:0] d);
    logic [7:0]  b [4];
    logic [31:0] r;
    for (int k = 0; k < 4; k++) b[k] = d[8*k +: 8];
    if (by) return {24'b0, b[lo]};
    for (int k = 0; k < 4; k++) r[8*k +: 8] = b[2'(int'(lo) + k)];
    return r;
  endfunction

  task automatic drive(input logic l, input logic s, input logic by, input logic [31:0] a,
                       input logic [31:0] sd, input logic [31:0] alu, input logic [3:0] rd,
                       input logic lk, input logic wb, input logic [3:0] cp);
    valid_in = 1; load_in = l; store_in = s; byte_in = by; addr_in = a; store_data_in = sd;
    alu_result_in = alu; rd_in = rd; link_in = lk; writeback_enable_in = wb; cpsr_status_in = cp;
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_req"}, mem_req, 0);
    chk({tag, "_we"}, mem_we, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
    chk({tag, "_wstrb"}, mem_wstrb, 0);
    chk({tag, "_valid"}, valid_out, 0);
    chk({tag, "_data"}, data_out, 0);
    chk({tag, "_rd"}, rd_out, 0);
    chk({tag, "_link"}, link_out, 0);
    chk({tag, "_wb"}, writeback_enable_out, 0);
    chk({tag, "_cpsr"}, cpsr_status_out, 0);
    chk({tag, "_fault"}, mem_fault_out, 0);
  endtask

  task automatic alu_op(input logic [31:0] alu, input logic [3:0] rd, input logic lk,
                        input logic wb, input logic [3:0] cp);
    drive(0, 0, 0, $urandom, $urandom, alu, rd, lk, wb, cp);
    #1 chk("alu_stall", stall_out, 0);
    step();
    chk("alu_valid", valid_out, 1);
    chk("alu_data", data_out, alu);
    chk("alu_rd", rd_out, rd);
    chk("alu_link", link_out, lk);
    chk("alu_wb", writeback_enable_out, wb);
    chk("alu_cpsr", cpsr_status_out, cp);
    chk("alu_req", mem_req, 0);
  endtask

  task automatic bubble();
    valid_in = 0;
    step();
    chk("bub_valid", valid_out, 0);
    chk("bub_wb", writeback_enable_out, 0);
  endtask

  task automatic mem_op(input logic l, input logic s, input logic by, input logic [31:0] a,
                        input logic [31:0] sd, input logic [31:0] alu, input logic [3:0] rd,
                        input logic lk, input logic wb, input logic [3:0] cp,
                        input int waits, input logic [31:0] rdata);
    logic [3:0] strb;
    strb = l ? 4'b0000 : by ? 4'b0001 << a[1:0] : 4'b1111;
    drive(l, s, by, a, sd, alu, rd, lk, wb, cp);
    #1 chk("acc_stall", stall_out, 1);
    step();
    chk("req_on", mem_req, 1);
    chk("req_we", mem_we, !l);
    chk("req_addr", mem_addr, {a[31:2], 2'b00});
    chk("req_wstrb", mem_wstrb, strb);
    if (!l) chk("req_wdata", mem_wdata, by ? {4{sd[7:0]}} : sd);
    chk("acc_valid", valid_out, 0);
    chk("acc_wb", writeback_enable_out, 0);
    for (int i = 0; i < waits; i++) begin
      mem_rdata = $urandom;
      #1 chk("wait_stall", stall_out, 1);
      step();
      chk("wait_req", mem_req, 1);
      chk("wait_valid", valid_out, 0);
    end
    mem_ack = 1; mem_rdata = rdata; valid_in = 0;
    #1 chk("ack_stall", stall_out, 0);
    step();
    mem_ack = 0;
    chk("done_req", mem_req, 0);
    chk("done_valid", valid_out, 1);
    chk("done_data", data_out, l ? load_model(by, a[1:0], rdata) : alu);
    chk("done_wb", writeback_enable_out, l & wb);
    chk("done_rd", rd_out, rd);
    chk("done_cpsr", cpsr_status_out, cp);
    chk("done_fault", mem_fault_out, 0);
  endtask

  initial begin
    step();
    step();
    reset = 0;
    all_zero("rst");
    chk("rst_stall", stall_out, 0);
    alu_op(32'h0000_1234, 4'd3, 0, 1, 4'h5);
    bubble();
    mem_op(1, 0, 0, 32'h100, 0, 32'h1, 4'd7, 0, 1, 4'h2, 2, 32'hDEAD_BEEF);
    mem_op(1, 0, 1, 32'h203, 0, 32'h2, 4'd1, 0, 1, 4'h0, 0, 32'hAABB_CCDD);
    mem_op(1, 0, 0, 32'h201, 0, 32'h3, 4'd2, 1, 1, 4'h9, 1, 32'hAABB_CCDD);
    mem_op(0, 1, 1, 32'h302, 32'h77, 32'h55, 4'd4, 0, 1, 4'h1, 3, 32'h0);
    mem_op(1, 1, 0, 32'h404, 32'h99, 32'h6, 4'd5, 0, 1, 4'h3, T - 1, 32'h1357_9BDF);
    drive(1, 0, 0, 32'h500, 0, 32'h8, 4'd6, 0, 1, 4'h4);
    #1 chk("to_stall0", stall_out, 1);
    step();
    for (int i = 1; i < T; i++) begin
      chk("to_wait_stall", stall_out, 1);
      chk("to_wait_req", mem_req, 1);
      step();
    end
    chk("to_last_stall", stall_out, 0);
    valid_in = 0;
    step();
    chk("to_req", mem_req, 0);
    chk("to_fault", mem_fault_out, 1);
    chk("to_valid", valid_out, 1);
    chk("to_wb", writeback_enable_out, 0);
    mem_ack = 1;
    step();
    mem_ack = 0;
    chk("to_fault_pulse", mem_fault_out, 0);
    chk("late_ack_valid", valid_out, 0);
    chk("late_ack_req", mem_req, 0);
    drive(1, 0, 0, 32'h600, 0, 32'h9, 4'd8, 0, 1, 4'h6);
    step();
    step();
    reset = 1;
    step();
    reset = 0;
    valid_in = 0;
    all_zero("midrst");
    mem_ack = 1;
    #1 chk("midrst_stall", stall_out, 0);
    step();
    mem_ack = 0;
    chk("midrst_ack_valid", valid_out, 0);
    chk("midrst_ack_req", mem_req, 0);
    for (int n = 0; n < 60; n++) begin
      int kind;
      kind = $urandom_range(0, 4);
      if (kind == 0) bubble();
      else if (kind == 1) alu_op($urandom, 4'($urandom), 1'($urandom), 1'($urandom), 4'($urandom));
      else begin
        logic l, s;
        l = 1'($urandom);
        s = !l | 1'($urandom);
        mem_op(l, s, 1'($urandom), $urandom, $urandom, $urandom, 4'($urandom), 1'($urandom),
               1'($urandom), 4'($urandom), $urandom_range(0, T - 1), $urandom);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
